// File: rtl/tt_factory_cnt_checker.sv
// Receive-side checker for the factory-test +1/cycle counter pattern.
// Locks onto the sequence, counts mismatches while locked and flags loss of lock.
module tt_factory_cnt_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [7:0]       data_in,
    input  logic             clear,
    output logic             locked,
    output logic             lost,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_sat,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_CNT - 1);

    logic            rst_n_i;
    logic [1:0]      state;
    logic [7:0]      exp;
    logic [GW-1:0]   good_run;
    logic [BW-1:0]   bad_run;

    // Release is delayed one edge so the first sample lands on a clean cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_n_i <= 1'b0;
        else        rst_n_i <= 1'b1;
    end

    // Handshake: en is a pure sample qualifier (no backpressure); data_in is
    // consumed on every rising edge where en=1 and ignored otherwise. clear
    // takes priority and discards any sample presented with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exp       <= 8'h00;
            good_run  <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            lost      <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else if (!rst_n_i || clear) begin
            state     <= IDLE;
            exp       <= 8'h00;
            good_run  <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            lost      <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else if (en) begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    exp      <= data_in + 8'd1;
                    good_run <= GW'(1);
                    state    <= ACQ;
                end
                ACQ: begin
                    // good_run==0 means we just dropped lock: reseed unconditionally.
                    if (good_run != '0 && data_in == exp) begin
                        exp      <= data_in + 8'd1;
                        good_run <= good_run + 1'b1;
                        if (good_run == LOCK_LAST) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            bad_run <= '0;
                        end
                    end else begin
                        exp      <= data_in + 8'd1;
                        good_run <= GW'(1);
                    end
                end
                LOCKED: begin
                    // Freewheel exp on mismatch so a single corrupted word costs one error.
                    exp <= exp + 8'd1;
                    if (data_in == exp) begin
                        bad_run <= '0;
                    end else begin
                        err_pulse <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        bad_run <= bad_run + 1'b1;
                        if (bad_run == LOSS_LAST) begin
                            state    <= ACQ;
                            locked   <= 1'b0;
                            lost     <= 1'b1;
                            good_run <= '0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end else begin
            err_pulse <= 1'b0;
        end
    end

    assign err_sat   = &err_cnt;
    assign state_dbg = state;

endmodule

// File: tb/tb_tt_factory_cnt_checker.sv
// Directed bench for tt_factory_cnt_checker (LOCK_CNT=4, LOSS_CNT=3, ERR_W=4).
module tb_tt_factory_cnt_checker;

    localparam int ERR_W = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_ACQ = 2'd1, S_LOCKED = 2'd2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [7:0]       data_in = 8'h00;
    logic             clear = 1'b0;
    logic             locked, lost, err_pulse, err_sat;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    tt_factory_cnt_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .clear(clear),
        .locked(locked), .lost(lost), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .err_sat(err_sat), .state_dbg(state_dbg)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Drivers: inputs change 1 time unit after the edge, outputs are read there too.
    task automatic cyc(input logic e, input logic [7:0] d, input logic c);
        en = e; data_in = d; clear = c;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    // Contiguous in-sequence stream; returns 1 if any err_pulse was seen.
    task automatic stream(input logic [7:0] first, input int count, output logic saw_err);
        logic [7:0] v;
        v = first;
        saw_err = 1'b0;
        for (int i = 0; i < count; i++) begin
            send(v);
            if (err_pulse) saw_err = 1'b1;
            v = v + 8'd1;
        end
    endtask

    initial begin
        logic       saw;
        logic [7:0] cur;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_lost", lost, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_sat", err_sat, 0);
        check("rst_state", state_dbg, S_IDLE);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);

        // 1: lock on 0x10..0x13
        send(8'h10); send(8'h11); send(8'h12);
        check("t1_not_yet_locked", locked, 0);
        send(8'h13);
        check("t1_locked", locked, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_lost", lost, 0);
        check("t1_state", state_dbg, S_LOCKED);

        // 2: wrap through 0xFF -> 0x00 -> 0x01
        stream(8'h14, 238, saw);
        check("t2_wrap_no_err", saw, 0);
        check("t2_locked", locked, 1);
        check("t2_err_cnt", err_cnt, 0);

        // 3: single corrupted word at exp=0x41
        stream(8'h02, 63, saw);
        check("t3_pre_no_err", saw, 0);
        send(8'h99);
        check("t3_err_pulse", err_pulse, 1);
        check("t3_err_cnt", err_cnt, 1);
        send(8'h42);
        check("t3_pulse_cleared", err_pulse, 0);
        check("t3_locked", locked, 1);
        check("t3_err_cnt_hold", err_cnt, 1);

        // 4: three consecutive mismatches drop lock, then relock
        stream(8'h43, 222, saw);
        check("t4_pre_no_err", saw, 0);
        send(8'h00);
        check("t4_bad1_locked", locked, 1);
        send(8'h00);
        check("t4_bad2_locked", locked, 1);
        check("t4_bad2_err_cnt", err_cnt, 3);
        send(8'h00);
        check("t4_bad3_unlocked", locked, 0);
        check("t4_bad3_lost", lost, 1);
        check("t4_bad3_err_cnt", err_cnt, 4);
        check("t4_bad3_state", state_dbg, S_ACQ);
        send(8'h50); send(8'h51); send(8'h52);
        check("t4_relock_pending", locked, 0);
        send(8'h53);
        check("t4_relocked", locked, 1);
        check("t4_lost_sticky", lost, 1);
        check("t4_no_acq_errors", err_cnt, 4);

        // 5: saturation at 15 with isolated errors, then clear with en=1
        cur = 8'h54;
        for (int i = 0; i < 20; i++) begin
            send(cur + 8'h80);
            cur = cur + 8'd1;
            if (i == 10) check("t5_reach_max", err_cnt, 15);
            send(cur);
            cur = cur + 8'd1;
        end
        send(cur + 8'h80);
        check("t5_sat_pulse", err_pulse, 1);
        check("t5_err_cnt_sat", err_cnt, 15);
        check("t5_err_sat", err_sat, 1);
        check("t5_still_locked", locked, 1);
        cyc(1'b1, cur + 8'd1, 1'b1);
        check("t5_clr_err_cnt", err_cnt, 0);
        check("t5_clr_err_sat", err_sat, 0);
        check("t5_clr_lost", lost, 0);
        check("t5_clr_locked", locked, 0);
        check("t5_clr_state_idle", state_dbg, S_IDLE);

        // 6: en toggling with junk data on idle cycles
        send(8'h30); cyc(1'b0, 8'hAA, 1'b0);
        send(8'h31); cyc(1'b0, 8'h55, 1'b0);
        send(8'h32); cyc(1'b0, 8'h00, 1'b0);
        check("t6_gap_not_locked", locked, 0);
        check("t6_gap_state", state_dbg, S_ACQ);
        send(8'h33);
        check("t6_gap_locked", locked, 1);
        cyc(1'b0, 8'hAA, 1'b0);
        send(8'h34);
        check("t6_gap_no_err", err_cnt, 0);
        send(8'h99);
        check("t6_err_pulse", err_pulse, 1);
        cyc(1'b0, 8'h99, 1'b0);
        check("t6_pulse_one_cycle", err_pulse, 0);
        check("t6_err_cnt", err_cnt, 1);

        // Async reset mid-LOCKED, checked before any clock edge
        rst_n = 1'b0;
        #2;
        check("t6_async_locked", locked, 0);
        check("t6_async_err_cnt", err_cnt, 0);
        check("t6_async_state", state_dbg, S_IDLE);
        @(posedge clk); #1;

        // The edge that releases the internal reset must not take a sample
        rst_n = 1'b1;
        send(8'h70);
        send(8'h71); send(8'h72); send(8'h73);
        check("t6_release_not_locked", locked, 0);
        send(8'h74);
        check("t6_release_locked", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
